// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding selects, stall/flush enables, start-up flush sequencing,
// memory-wait freeze with timeout watchdog, and saturating stall/flush statistics.
module hazard_ctrl #(
    parameter int RESET_FLUSH = 3,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic [4:0]       Rs1_E,
    input  logic [4:0]       Rs2_E,
    input  logic [4:0]       Rd_E,
    input  logic [1:0]       ResultSrc_E,
    input  logic             PCSrc_E,
    input  logic [4:0]       Rd_M,
    input  logic [4:0]       Rd_W,
    input  logic             RegWrite_M,
    input  logic             RegWrite_W,
    input  logic             MemReq_M,
    input  logic             MemReady,
    output logic [1:0]       ForwardA_E,
    output logic [1:0]       ForwardB_E,
    output logic             Stall_F,
    output logic             Stall_D,
    output logic             Stall_E,
    output logic             Stall_M,
    output logic             Flush_D,
    output logic             Flush_E,
    output logic             Flush_W,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);
    localparam int IW = $clog2(RESET_FLUSH + 1);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {INIT, RUN, MEM_WAIT, ERR} state_t;

    state_t           r_state, w_next;
    logic [IW-1:0]    r_init_cnt;
    logic [WW-1:0]    r_wait_cnt, w_wait_next;
    logic             r_err;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
    logic             w_mw, w_lw, w_active;

    assign w_mw     = MemReq_M & ~MemReady;
    assign w_lw     = ResultSrc_E == 2'b01 && Rd_E != 5'd0 && (Rd_E == Rs1_D || Rd_E == Rs2_D);
    assign w_active = !rst && (r_state == RUN || r_state == MEM_WAIT);

    // Memory stage has priority over Writeback since it holds the younger result.
    assign ForwardA_E = !w_active ? 2'b00 :
                        (RegWrite_M && Rd_M != 5'd0 && Rd_M == Rs1_E) ? 2'b10 :
                        (RegWrite_W && Rd_W != 5'd0 && Rd_W == Rs1_E) ? 2'b01 : 2'b00;
    assign ForwardB_E = !w_active ? 2'b00 :
                        (RegWrite_M && Rd_M != 5'd0 && Rd_M == Rs2_E) ? 2'b10 :
                        (RegWrite_W && Rd_W != 5'd0 && Rd_W == Rs2_E) ? 2'b01 : 2'b00;

    assign MemErr     = r_err;
    assign StallCount = r_stall_cnt;
    assign FlushCount = r_flush_cnt;

    always_comb begin
        w_next      = r_state;
        w_wait_next = r_wait_cnt;
        Stall_F     = 1'b0;
        Stall_D     = 1'b0;
        Stall_E     = 1'b0;
        Stall_M     = 1'b0;
        Flush_D     = 1'b0;
        Flush_E     = 1'b0;
        Flush_W     = 1'b0;
        if (rst || r_state == INIT) begin
            Stall_F = 1'b1;
            Flush_D = 1'b1;
            Flush_E = 1'b1;
            Flush_W = 1'b1;
        end else if (r_state == ERR || w_mw) begin
            // A frozen pipe keeps any pending branch/load-use until it thaws.
            Stall_F = 1'b1;
            Stall_D = 1'b1;
            Stall_E = 1'b1;
            Stall_M = 1'b1;
            Flush_W = 1'b1;
        end else begin
            Stall_F = w_lw;
            Stall_D = w_lw;
            Flush_D = PCSrc_E;
            Flush_E = w_lw | PCSrc_E;
        end
        case (r_state)
            INIT: w_next = r_init_cnt <= IW'(1) ? RUN : INIT;
            RUN: begin
                w_next      = w_mw ? MEM_WAIT : RUN;
                w_wait_next = w_mw ? WW'(1) : '0;
            end
            MEM_WAIT: begin
                w_next      = !w_mw ? RUN : (r_wait_cnt == WW'(MEM_TIMEOUT - 1)) ? ERR : MEM_WAIT;
                w_wait_next = !w_mw ? '0 : r_wait_cnt + 1'b1;
            end
            default: w_next = ERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= INIT;
            r_init_cnt  <= IW'(RESET_FLUSH);
            r_wait_cnt  <= '0;
            r_err       <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= w_wait_next;
            r_err      <= w_next == ERR;
            if (r_state == INIT)
                r_init_cnt <= r_init_cnt - 1'b1;
            if (w_active && Stall_F && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (r_state == RUN && !w_mw && PCSrc_E && !(&r_flush_cnt))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random stimulus; a driver pushes reference-model
// expectations into a queue that a negedge monitor pops and compares.
module tb_hazard_ctrl;
    localparam int RF   = 3;
    localparam int TO   = 16;
    localparam int CW   = 5;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic       rst, pcsrc, rwm, rww, memreq, memready;
        logic [1:0] rsrc;
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    } stim_t;

    typedef struct packed {
        logic [1:0]  fa, fb;
        logic [3:0]  stl;
        logic [2:0]  fl;
        logic        err;
        logic [31:0] scnt, fcnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
    logic [1:0] ResultSrc_E, ForwardA_E, ForwardB_E;
    logic PCSrc_E, RegWrite_M, RegWrite_W, MemReq_M, MemReady;
    logic Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W, MemErr;
    logic [CW-1:0] StallCount, FlushCount;

    hazard_ctrl #(.RESET_FLUSH(RF), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E),
        .ResultSrc_E(ResultSrc_E), .PCSrc_E(PCSrc_E),
        .Rd_M(Rd_M), .Rd_W(Rd_W), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .MemReq_M(MemReq_M), .MemReady(MemReady),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E), .Stall_M(Stall_M),
        .Flush_D(Flush_D), .Flush_E(Flush_E), .Flush_W(Flush_W),
        .MemErr(MemErr), .StallCount(StallCount), .FlushCount(FlushCount)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: cycles left in start-up, length of the current freeze, error flag.
    int m_init, m_wait, m_scnt, m_fcnt;
    bit m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("fwdA", 32'(ForwardA_E), 32'(e.fa));
            chk("fwdB", 32'(ForwardB_E), 32'(e.fb));
            chk("stalls", 32'({Stall_F, Stall_D, Stall_E, Stall_M}), 32'(e.stl));
            chk("flushes", 32'({Flush_D, Flush_E, Flush_W}), 32'(e.fl));
            chk("memerr", 32'(MemErr), 32'(e.err));
            chk("stallcnt", 32'(StallCount), e.scnt);
            chk("flushcnt", 32'(FlushCount), e.fcnt);
        end
    end

    function automatic logic [1:0] fwd(input logic [4:0] rs, input stim_t s);
        if (s.rwm && s.rdm != 0 && s.rdm == rs) return 2'b10;
        if (s.rww && s.rdw != 0 && s.rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic apply(input stim_t s);
        rst = s.rst; PCSrc_E = s.pcsrc; RegWrite_M = s.rwm; RegWrite_W = s.rww;
        MemReq_M = s.memreq; MemReady = s.memready; ResultSrc_E = s.rsrc;
        Rs1_D = s.rs1d; Rs2_D = s.rs2d; Rs1_E = s.rs1e; Rs2_E = s.rs2e;
        Rd_E = s.rde; Rd_M = s.rdm; Rd_W = s.rdw;
    endtask

    task automatic cyc(input stim_t s);
        exp_t e;
        bit lw, br, mw;
        apply(s);
        e = '0;
        e.err  = m_err;
        e.scnt = 32'(m_scnt);
        e.fcnt = 32'(m_fcnt);
        lw = s.rsrc == 2'b01 && s.rde != 0 && (s.rde == s.rs1d || s.rde == s.rs2d);
        br = s.pcsrc;
        mw = s.memreq && !s.memready;
        if (s.rst || (!m_err && m_init > 0)) begin
            e.stl = 4'b1000; e.fl = 3'b111;
        end else if (m_err || mw) begin
            e.stl = 4'b1111; e.fl = 3'b001;
        end else begin
            e.stl = {lw, lw, 2'b00}; e.fl = {br, lw | br, 1'b0};
        end
        if (!s.rst && !m_err && m_init == 0) begin
            e.fa = fwd(s.rs1e, s);
            e.fb = fwd(s.rs2e, s);
        end
        q.push_back(e);
        if (s.rst) begin
            m_init = RF; m_wait = 0; m_err = 0; m_scnt = 0; m_fcnt = 0;
        end else if (!m_err && m_init > 0) begin
            m_init--;
        end else if (!m_err) begin
            if (e.stl[3] && m_scnt < CMAX) m_scnt++;
            if (!mw && br && m_wait == 0 && m_fcnt < CMAX) m_fcnt++;
            if (mw) begin
                m_wait++;
                if (m_wait >= TO) m_err = 1;
            end else m_wait = 0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        stim_t s;
        int hang;
        s = '0;
        s.rst = 1'b1;
        apply(s);
        repeat (2) @(posedge clk);
        #1;
        m_init = RF; m_wait = 0; m_err = 0; m_scnt = 0; m_fcnt = 0;
        s = '0;
        repeat (5) cyc(s);
        s.rwm = 1; s.rdm = 5; s.rww = 1; s.rdw = 5; s.rs1e = 5; s.rs2e = 6;
        cyc(s);
        s.rwm = 0;
        cyc(s);
        s.rwm = 1; s.rdm = 0; s.rdw = 0; s.rs1e = 0; s.rs2e = 0;
        cyc(s);
        s = '0;
        s.rsrc = 2'b01; s.rde = 10; s.rs1d = 10;
        cyc(s);
        s = '0;
        s.pcsrc = 1;
        cyc(s);
        s = '0;
        s.rsrc = 2'b01; s.rde = 0; s.rs1d = 0;
        cyc(s);
        s = '0;
        s.memreq = 1; s.pcsrc = 1;
        repeat (4) cyc(s);
        s.memready = 1;
        cyc(s);
        s = '0;
        s.memreq = 1;
        repeat (20) cyc(s);
        s = '0;
        s.rst = 1;
        cyc(s);
        s.rst = 0;
        repeat (5) cyc(s);
        s.rsrc = 2'b01; s.rde = 7; s.rs2d = 7;
        repeat (40) cyc(s);
        hang = 0;
        for (int i = 0; i < 3000; i++) begin
            s = '0;
            s.rst = ($urandom_range(0, 299) == 0) || (m_err && $urandom_range(0, 9) == 0);
            s.rs1d = 5'($urandom_range(0, 3)); s.rs2d = 5'($urandom_range(0, 3));
            s.rs1e = 5'($urandom_range(0, 3)); s.rs2e = 5'($urandom_range(0, 3));
            s.rde = 5'($urandom_range(0, 3)); s.rdm = 5'($urandom_range(0, 3));
            s.rdw = 5'($urandom_range(0, 3)); s.rsrc = 2'($urandom_range(0, 3));
            s.pcsrc = $urandom_range(0, 5) == 0;
            s.rwm = 1'($urandom_range(0, 1)); s.rww = 1'($urandom_range(0, 1));
            if (hang > 0) begin
                s.memreq = 1; s.memready = 0; hang--;
            end else begin
                s.memreq = $urandom_range(0, 2) == 0;
                s.memready = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 300) == 0) hang = 20;
            end
            cyc(s);
        end
        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
